zap_wb_sram_responder: RTL and testbench
========================================

Name: zap_wb_sram_responder

Overview:
Wishbone B3 responder at the far end of the merged ZAP bus. It terminates classic and linear incrementing-burst cycles into an internal word-wide SRAM.
- Wait-state insertion is programmable.
- Byte-lane writes use i_wb_sel.
- Accesses outside the array are reported through o_wb_err.
- Serves as the on-chip RAM target and as the bench model for the merger and the caches.

Parameters:
DEPTH, 1024, number of 32-bit words (power of two); ADDR_W = log2(DEPTH), derived
WAIT_STATES, 1, extra cycles (0..15) between request sample and first ack/err

Ports:
i_clk  in  1  clock, rising edge
i_reset_n  in  1  reset, asynchronous, active-low
i_wb_cyc  in  1  cycle valid
i_wb_stb  in  1  strobe
i_wb_wen  in  1  1=write, 0=read
i_wb_sel  in  4  byte lane enables, bit n = dat[8n+7:8n]
i_wb_dat  in  32  write data
i_wb_adr  in  32  byte address; word index = adr[ADDR_W+1:2]
i_wb_cti  in  3  000 classic, 010 incrementing burst, 111 end-of-burst
o_wb_dat  out  32  read data, valid while o_wb_ack=1 on a read
o_wb_ack  out  1  transfer acknowledge
o_wb_err  out  1  out-of-range termination

Behaviour:
- Clocking and reset:
  - One clock, i_clk.
  - Reset i_reset_n is asynchronous, active-low.
  - While reset is asserted: state=IDLE, o_wb_ack=0, o_wb_err=0, o_wb_dat=0, wait counter=0, burst address=0.
  - Memory contents are not reset.
- Request sampling:
  - req = i_wb_cyc & i_wb_stb.
  - oor = (i_wb_adr[31:ADDR_W+2] != 0), evaluated on the current address (sampled, or internal in BURST).
- States:
  - IDLE: on req, latch wen, word address and cti into registers.
    - If WAIT_STATES==0: go to ACK (classic) or BURST (cti==010).
    - Otherwise: load counter=WAIT_STATES-1 and go to WAIT.
  - WAIT: counter decrements each cycle. At counter==0, go to ACK or BURST per latched cti.
    - Classic latency: ack is high in cycle WAIT_STATES+1 after the sampling edge.
  - ACK: registered ack_ff (or err_ff if oor) is high for exactly one cycle, then IDLE.
    - The cycle after ACK is never treated as a continuation. A held strobe there is a new request.
  - BURST: ack_ff is high every cycle.
    - At each edge ending an acked beat, the internal word address increments by 1.
    - The burst ends, returning to IDLE with ack low next cycle, when either:
      - the beat just acked had i_wb_cti==111; or
      - i_wb_cti==000 was presented.
- Output gating:
  - o_wb_ack = ack_ff & req & ~oor_cur.
  - o_wb_err = ack_ff & req & oor_cur.
  - No ack or err is ever driven while stb is low.
- Read data:
  - The SRAM is read synchronously one cycle ahead, so o_wb_dat holds mem[addr] during every ack cycle.
  - In BURST the prefetch uses address+1.
  - o_wb_dat=0 when err is driven.
- Write:
  - Performed at the edge ending an ack cycle with wen=1.
  - Only lanes with i_wb_sel set are updated; sel=0000 writes nothing but is still acked.
  - No write on err.
- Address wrap: none. A burst stepping past DEPTH-1 terminates that beat with o_wb_err and returns to IDLE.
- Abort:
  - i_wb_cyc low in any non-IDLE state: IDLE next cycle, no ack/err, no write.
  - i_wb_stb low with cyc high in BURST: pause. State, address and ack_ff are held; the address does not advance.
- Mid-operation changes: i_wb_wen/i_wb_adr changes mid-burst are ignored. Latched wen and the internal address govern the burst.
- Reset assertion mid-operation: immediate return to reset values; any in-flight write is not performed.

Decomposition:
- Shared package (zap_localparams.vh): CTI_CLASSIC=3'b000, CTI_INCR=3'b010, CTI_EOB=3'b111, and state encodings IDLE/WAIT/ACK/BURST.
- One sub-module: zap_sram_bytewen. Parameters DEPTH; ports clk, rd_addr, rd_data (registered), wr_en, wr_sel[3:0], wr_addr, wr_data. The responder instantiates it once.

Test Plan:
- Classic write then read, WAIT_STATES=2:
  - Stimulus: write 0xDEADBEEF to 0x40 with sel=1111, then a read of 0x40.
  - Response: each ack appears exactly 3 cycles after stb is sampled; read returns 0xDEADBEEF; ack width is 1 cycle.
- Byte lanes:
  - Stimulus: write 0xAABBCCDD with sel=0101 to a word preloaded with 0x11223344.
  - Response: readback 0x11BB33DD; sel=0000 write is acked with data unchanged.
- 4-beat incrementing burst read, WAIT_STATES=0:
  - Stimulus: start at 0x100, cti 010,010,010,111, with memory preloaded with 0,1,2,3.
  - Response: acks on 4 consecutive cycles, o_wb_dat=0,1,2,3; ack low on cycle 5.
- Burst pause and abort:
  - Stimulus: drop stb for 2 cycles after beat 2; separately, drop cyc mid-WAIT on a write.
  - Response: the pause produces no ack and the address holds, and beat 3 resumes at adr+8 data. The aborted write leaves memory unchanged and the block is back in IDLE.
- Out of range:
  - Stimulus: a read at DEPTH*4; a burst starting at word DEPTH-2 running for 3 beats.
  - Response: the read gets o_wb_err=1 with o_wb_ack=0 and dat=0. The burst acks beats 1-2 and errs beat 3.
- Async reset:
  - Stimulus: assert i_reset_n=0 mid-burst between clock edges.
  - Response: o_wb_ack/o_wb_err drop to 0 immediately (before the next edge); state is IDLE after release.

Source files
------------

// File: rtl/zap_wb_sram_responder_pkg.sv
// Shared constants for the ZAP Wishbone SRAM responder: cycle-type codes and FSM states.
package zap_wb_sram_responder_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ACK   = 2'd2,
        ST_BURST = 2'd3
    } state_t;

endpackage

// File: rtl/zap_wb_sram_responder_if.sv
// Wishbone B3 bus bundle between the merged ZAP bus and the SRAM responder.
interface zap_wb_sram_responder_if;

    logic        i_wb_cyc;
    logic        i_wb_stb;
    logic        i_wb_wen;
    logic [3:0]  i_wb_sel;
    logic [31:0] i_wb_dat;
    logic [31:0] i_wb_adr;
    logic [2:0]  i_wb_cti;
    logic [31:0] o_wb_dat;
    logic        o_wb_ack;
    logic        o_wb_err;

    modport slave (
        input  i_wb_cyc, i_wb_stb, i_wb_wen, i_wb_sel, i_wb_dat, i_wb_adr, i_wb_cti,
        output o_wb_dat, o_wb_ack, o_wb_err
    );

    modport master (
        output i_wb_cyc, i_wb_stb, i_wb_wen, i_wb_sel, i_wb_dat, i_wb_adr, i_wb_cti,
        input  o_wb_dat, o_wb_ack, o_wb_err
    );

endinterface

// File: rtl/zap_sram_bytewen.sv
// Word-wide SRAM with byte-lane write enables and a registered read port.
module zap_sram_bytewen #(
    parameter  int DEPTH  = 1024,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [31:0]       rd_data,
    input  logic              wr_en,
    input  logic [3:0]        wr_sel,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [31:0]       wr_data
);

    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_sel[b]) r_mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
        rd_data <= r_mem[rd_addr];
    end

endmodule

// File: rtl/zap_wb_sram_responder.sv
// Wishbone B3 responder terminating classic and incrementing-burst cycles into on-chip SRAM.
// State table: IDLE = waiting for request | WAIT = counting wait states | ACK = one classic ack | BURST = ack every strobed beat
module zap_wb_sram_responder
    import zap_wb_sram_responder_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    zap_wb_sram_responder_if.slave  wb
);

    localparam int         ADDR_W  = $clog2(DEPTH);
    localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t            r_state;
    logic              r_wen;
    logic [2:0]        r_cti;
    logic [29:0]       r_addr;
    logic [3:0]        r_wait;
    logic              r_ack_ff;

    logic              w_req;
    logic              w_oor;
    logic              w_beat;
    logic              w_ack;
    logic              w_err;
    logic              w_wr_en;
    logic [29:0]       w_cur_addr;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [31:0]       w_rd_data;

    assign w_req      = wb.i_wb_cyc & wb.i_wb_stb;
    assign w_cur_addr = (r_state == ST_IDLE) ? wb.i_wb_adr[31:2] : r_addr;
    assign w_oor      = (w_cur_addr[29:ADDR_W] != '0);
    assign w_beat     = r_ack_ff & w_req;
    assign w_ack      = w_beat & ~w_oor;
    assign w_err      = w_beat & w_oor;
    assign w_wr_en    = w_ack & r_wen;

    assign wb.o_wb_ack = w_ack;
    assign wb.o_wb_err = w_err;
    assign wb.o_wb_dat = w_ack ? w_rd_data : 32'h0;

    // Read one cycle ahead so the data is already in the SRAM output register when ack rises.
    always_comb begin
        w_rd_addr = r_addr[ADDR_W-1:0];
        if (r_state == ST_IDLE) begin
            w_rd_addr = wb.i_wb_adr[ADDR_W+1:2];
        end else if ((r_state == ST_BURST) && w_beat) begin
            w_rd_addr = r_addr[ADDR_W-1:0] + ADDR_W'(1);
        end
    end

    zap_sram_bytewen #(.DEPTH(DEPTH)) u_sram (
        .clk     (i_clk),
        .rd_addr (w_rd_addr),
        .rd_data (w_rd_data),
        .wr_en   (w_wr_en),
        .wr_sel  (wb.i_wb_sel),
        .wr_addr (r_addr[ADDR_W-1:0]),
        .wr_data (wb.i_wb_dat)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state  <= ST_IDLE;
            r_wen    <= 1'b0;
            r_cti    <= CTI_CLASSIC;
            r_addr   <= '0;
            r_wait   <= '0;
            r_ack_ff <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_wen  <= wb.i_wb_wen;
                        r_cti  <= wb.i_wb_cti;
                        r_addr <= wb.i_wb_adr[31:2];
                        if (WAIT_STATES == 0) begin
                            r_state  <= (wb.i_wb_cti == CTI_INCR) ? ST_BURST : ST_ACK;
                            r_ack_ff <= 1'b1;
                        end else begin
                            r_wait  <= WS_LOAD;
                            r_state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!wb.i_wb_cyc) begin
                        r_state <= ST_IDLE;
                    end else if (r_wait == 4'd0) begin
                        r_state  <= (r_cti == CTI_INCR) ? ST_BURST : ST_ACK;
                        r_ack_ff <= 1'b1;
                    end else begin
                        r_wait <= r_wait - 4'd1;
                    end
                end
                ST_ACK: begin
                    r_state  <= ST_IDLE;
                    r_ack_ff <= 1'b0;
                end
                ST_BURST: begin
                    if (!wb.i_wb_cyc) begin
                        r_state  <= ST_IDLE;
                        r_ack_ff <= 1'b0;
                    end else if (w_beat) begin
                        // An errored beat past the array end also closes the burst.
                        if (w_oor || (wb.i_wb_cti == CTI_EOB) || (wb.i_wb_cti == CTI_CLASSIC)) begin
                            r_state  <= ST_IDLE;
                            r_ack_ff <= 1'b0;
                        end else begin
                            r_addr <= r_addr + 30'd1;
                        end
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_ack_ff <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_zap_wb_sram_responder.sv
// Directed bench: one responder with two wait states and one with none, sharing a single bus driver.
module tb_zap_wb_sram_responder;
    import zap_wb_sram_responder_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        use_w0;
    logic        cyc, stb, wen;
    logic [3:0]  sel;
    logic [31:0] wdat, adr;
    logic [2:0]  cti;
    logic        ack, err;
    logic [31:0] rdat;
    int          n_chk;
    int          n_pass;

    zap_wb_sram_responder_if bus_w2 ();
    zap_wb_sram_responder_if bus_w0 ();

    assign bus_w2.i_wb_cyc = use_w0 ? 1'b0 : cyc;
    assign bus_w2.i_wb_stb = use_w0 ? 1'b0 : stb;
    assign bus_w2.i_wb_wen = wen;
    assign bus_w2.i_wb_sel = sel;
    assign bus_w2.i_wb_dat = wdat;
    assign bus_w2.i_wb_adr = adr;
    assign bus_w2.i_wb_cti = cti;
    assign bus_w0.i_wb_cyc = use_w0 ? cyc : 1'b0;
    assign bus_w0.i_wb_stb = use_w0 ? stb : 1'b0;
    assign bus_w0.i_wb_wen = wen;
    assign bus_w0.i_wb_sel = sel;
    assign bus_w0.i_wb_dat = wdat;
    assign bus_w0.i_wb_adr = adr;
    assign bus_w0.i_wb_cti = cti;
    assign ack  = use_w0 ? bus_w0.o_wb_ack : bus_w2.o_wb_ack;
    assign err  = use_w0 ? bus_w0.o_wb_err : bus_w2.o_wb_err;
    assign rdat = use_w0 ? bus_w0.o_wb_dat : bus_w2.o_wb_dat;

    zap_wb_sram_responder #(.DEPTH(1024), .WAIT_STATES(2)) dut_w2 (
        .i_clk(clk), .i_reset_n(rst_n), .wb(bus_w2));
    zap_wb_sram_responder #(.DEPTH(1024), .WAIT_STATES(0)) dut_w0 (
        .i_clk(clk), .i_reset_n(rst_n), .wb(bus_w0));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Classic cycle driver: lat is the cycle index (after the sampling edge) of the first ack/err.
    task automatic bus_classic(input logic we, input logic [31:0] a_in, input logic [3:0] s_in,
                               input logic [31:0] d_in, input logic hold,
                               output int lat, output logic [31:0] q, output logic got_ack,
                               output logic got_err, output logic extra);
        cyc = 1'b1; stb = 1'b1; wen = we; adr = a_in; sel = s_in; wdat = d_in; cti = CTI_CLASSIC;
        lat = 0; q = '0; got_ack = 1'b0; got_err = 1'b0; extra = 1'b0;
        @(posedge clk);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (ack || err) begin
                lat = k; q = rdat; got_ack = ack; got_err = err;
                break;
            end
        end
        @(posedge clk); #1;
        if (hold) begin
            @(negedge clk); extra = ack | err;
            @(posedge clk); #1;
        end
        cyc = 1'b0; stb = 1'b0; wen = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Incrementing read burst driver; optional 2-cycle strobe pause after beat pause_after.
    task automatic bus_burst(input logic [31:0] a_in, input int nbeats, input int pause_after,
                             output logic [3:0][31:0] q, output logic [3:0] a, output logic [3:0] e,
                             output int first_lat, output int gaps, output logic pause_ack,
                             output logic tail_ack);
        int beat, cycles;
        cyc = 1'b1; stb = 1'b1; wen = 1'b0; adr = a_in; sel = 4'hF;
        cti = (nbeats == 1) ? CTI_EOB : CTI_INCR;
        q = '0; a = '0; e = '0; first_lat = 0; gaps = 0; pause_ack = 1'b0; tail_ack = 1'b0;
        beat = 0; cycles = 0;
        @(posedge clk);
        while (beat < nbeats && cycles < 40) begin
            @(negedge clk); cycles++;
            if (ack || err) begin
                if (beat == 0) first_lat = cycles;
                q[beat] = rdat; a[beat] = ack; e[beat] = err;
                beat++;
                if (err) beat = nbeats;
                @(posedge clk); #1;
                adr = adr + 32'd4;
                cti = (beat == nbeats - 1) ? CTI_EOB : CTI_INCR;
                if (beat == pause_after) begin
                    stb = 1'b0;
                    repeat (2) begin
                        @(negedge clk); pause_ack = pause_ack | ack | err;
                        @(posedge clk); #1;
                    end
                    stb = 1'b1;
                end
            end else begin
                if (beat > 0) gaps++;
                @(posedge clk); #1;
            end
        end
        cti = CTI_CLASSIC;
        @(negedge clk); tail_ack = ack | err;
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cyc = 1'b1; stb = 1'b1;
        @(negedge clk);
        n_chk++; if (bus_w2.o_wb_ack !== 1'b0) $display("FAIL reset_ack_w2 got %0b want 0", bus_w2.o_wb_ack); else n_pass++;
        n_chk++; if (bus_w2.o_wb_err !== 1'b0) $display("FAIL reset_err_w2 got %0b want 0", bus_w2.o_wb_err); else n_pass++;
        n_chk++; if (bus_w2.o_wb_dat !== 32'h0) $display("FAIL reset_dat_w2 got %h want 0", bus_w2.o_wb_dat); else n_pass++;
        n_chk++; if (bus_w0.o_wb_ack !== 1'b0) $display("FAIL reset_ack_w0 got %0b want 0", bus_w0.o_wb_ack); else n_pass++;
        n_chk++; if (bus_w0.o_wb_dat !== 32'h0) $display("FAIL reset_dat_w0 got %h want 0", bus_w0.o_wb_dat); else n_pass++;
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_classic();
        int lat; logic [31:0] q; logic ga, ge, ex;
        use_w0 = 1'b0;
        bus_classic(1'b1, 32'h40, 4'hF, 32'hDEADBEEF, 1'b1, lat, q, ga, ge, ex);
        n_chk++; if (lat !== 3) $display("FAIL classic_wr_latency got %0d want 3", lat); else n_pass++;
        n_chk++; if (ge !== 1'b0) $display("FAIL classic_wr_err got %0b want 0", ge); else n_pass++;
        n_chk++; if (ex !== 1'b0) $display("FAIL classic_wr_ack_width got %0b want 0", ex); else n_pass++;
        bus_classic(1'b0, 32'h40, 4'hF, 32'h0, 1'b1, lat, q, ga, ge, ex);
        n_chk++; if (lat !== 3) $display("FAIL classic_rd_latency got %0d want 3", lat); else n_pass++;
        n_chk++; if (q !== 32'hDEADBEEF) $display("FAIL classic_rd_data got %h want deadbeef", q); else n_pass++;
        n_chk++; if (ex !== 1'b0) $display("FAIL classic_rd_ack_width got %0b want 0", ex); else n_pass++;
    endtask

    task automatic test_byte_lanes();
        int lat; logic [31:0] q; logic ga, ge, ex;
        use_w0 = 1'b0;
        bus_classic(1'b1, 32'h80, 4'hF, 32'h11223344, 1'b0, lat, q, ga, ge, ex);
        bus_classic(1'b1, 32'h80, 4'b0101, 32'hAABBCCDD, 1'b0, lat, q, ga, ge, ex);
        n_chk++; if (lat !== 3) $display("FAIL lanes_wr_latency got %0d want 3", lat); else n_pass++;
        bus_classic(1'b0, 32'h80, 4'hF, 32'h0, 1'b0, lat, q, ga, ge, ex);
        n_chk++; if (q !== 32'h11BB33DD) $display("FAIL lanes_merge got %h want 11bb33dd", q); else n_pass++;
        bus_classic(1'b1, 32'h80, 4'b0000, 32'hFFFFFFFF, 1'b0, lat, q, ga, ge, ex);
        n_chk++; if (ga !== 1'b1 || lat !== 3) $display("FAIL lanes_sel0_ack got ack=%0b lat=%0d want ack=1 lat=3", ga, lat); else n_pass++;
        bus_classic(1'b0, 32'h80, 4'hF, 32'h0, 1'b0, lat, q, ga, ge, ex);
        n_chk++; if (q !== 32'h11BB33DD) $display("FAIL lanes_sel0_unchanged got %h want 11bb33dd", q); else n_pass++;
    endtask

    task automatic test_burst();
        int lat, fl, gp; logic [31:0] q1; logic ga, ge, ex, pa, ta;
        logic [3:0][31:0] q; logic [3:0] a, e;
        use_w0 = 1'b1;
        for (int i = 0; i < 4; i++)
            bus_classic(1'b1, 32'h100 + 32'(4*i), 4'hF, 32'(i), 1'b0, lat, q1, ga, ge, ex);
        n_chk++; if (lat !== 1) $display("FAIL w0_classic_latency got %0d want 1", lat); else n_pass++;
        bus_burst(32'h100, 4, 99, q, a, e, fl, gp, pa, ta);
        n_chk++; if (fl !== 1) $display("FAIL burst_first_latency got %0d want 1", fl); else n_pass++;
        n_chk++; if (gp !== 0) $display("FAIL burst_consecutive gaps got %0d want 0", gp); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_chk++; if (q[i] !== 32'(i)) $display("FAIL burst_data beat %0d got %h want %h", i, q[i], 32'(i)); else n_pass++;
        end
        n_chk++; if (ta !== 1'b0) $display("FAIL burst_ack_after_eob got %0b want 0", ta); else n_pass++;
    endtask

    task automatic test_pause_abort();
        int lat, fl, gp; logic [31:0] q1; logic ga, ge, ex, pa, ta, seen;
        logic [3:0][31:0] q; logic [3:0] a, e;
        use_w0 = 1'b1;
        bus_burst(32'h100, 4, 2, q, a, e, fl, gp, pa, ta);
        n_chk++; if (pa !== 1'b0) $display("FAIL pause_ack got %0b want 0", pa); else n_pass++;
        n_chk++; if (q[2] !== 32'd2) $display("FAIL pause_resume_beat3 got %h want 2", q[2]); else n_pass++;
        n_chk++; if (q[3] !== 32'd3) $display("FAIL pause_resume_beat4 got %h want 3", q[3]); else n_pass++;
        use_w0 = 1'b0;
        cyc = 1'b1; stb = 1'b1; wen = 1'b1; adr = 32'h40; sel = 4'hF; wdat = 32'h12345678; cti = CTI_CLASSIC;
        @(posedge clk); #1;
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; wen = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk); seen = seen | ack | err;
            @(posedge clk); #1;
        end
        n_chk++; if (seen !== 1'b0) $display("FAIL abort_no_ack got %0b want 0", seen); else n_pass++;
        bus_classic(1'b0, 32'h40, 4'hF, 32'h0, 1'b0, lat, q1, ga, ge, ex);
        n_chk++; if (lat !== 3) $display("FAIL abort_idle_latency got %0d want 3", lat); else n_pass++;
        n_chk++; if (q1 !== 32'hDEADBEEF) $display("FAIL abort_mem_unchanged got %h want deadbeef", q1); else n_pass++;
    endtask

    task automatic test_out_of_range();
        int lat, fl, gp; logic [31:0] q1; logic ga, ge, ex, pa, ta;
        logic [3:0][31:0] q; logic [3:0] a, e;
        use_w0 = 1'b0;
        bus_classic(1'b0, 32'h1000, 4'hF, 32'h0, 1'b0, lat, q1, ga, ge, ex);
        n_chk++; if (ge !== 1'b1 || lat !== 3) $display("FAIL oor_read_err got err=%0b lat=%0d want err=1 lat=3", ge, lat); else n_pass++;
        n_chk++; if (ga !== 1'b0) $display("FAIL oor_read_ack got %0b want 0", ga); else n_pass++;
        n_chk++; if (q1 !== 32'h0) $display("FAIL oor_read_dat got %h want 0", q1); else n_pass++;
        use_w0 = 1'b1;
        bus_burst(32'hFF8, 3, 99, q, a, e, fl, gp, pa, ta);
        n_chk++; if (a[1:0] !== 2'b11 || e[1:0] !== 2'b00) $display("FAIL oor_burst_beats12 got ack=%b err=%b want ack=11 err=00", a[1:0], e[1:0]); else n_pass++;
        n_chk++; if (e[2] !== 1'b1 || a[2] !== 1'b0) $display("FAIL oor_burst_beat3 got ack=%0b err=%0b want ack=0 err=1", a[2], e[2]); else n_pass++;
        n_chk++; if (q[2] !== 32'h0) $display("FAIL oor_burst_dat got %h want 0", q[2]); else n_pass++;
        n_chk++; if (ta !== 1'b0) $display("FAIL oor_burst_idle got %0b want 0", ta); else n_pass++;
    endtask

    task automatic test_async_reset();
        int lat; logic [31:0] q1; logic ga, ge, ex;
        use_w0 = 1'b1;
        cyc = 1'b1; stb = 1'b1; wen = 1'b0; adr = 32'h100; sel = 4'hF; cti = CTI_INCR;
        @(posedge clk);
        @(negedge clk);
        n_chk++; if (ack !== 1'b1) $display("FAIL areset_pre_ack got %0b want 1", ack); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_chk++; if (ack !== 1'b0) $display("FAIL areset_ack_drop got %0b want 0", ack); else n_pass++;
        n_chk++; if (err !== 1'b0) $display("FAIL areset_err_drop got %0b want 0", err); else n_pass++;
        n_chk++; if (rdat !== 32'h0) $display("FAIL areset_dat_drop got %h want 0", rdat); else n_pass++;
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;
        bus_classic(1'b0, 32'h104, 4'hF, 32'h0, 1'b0, lat, q1, ga, ge, ex);
        n_chk++; if (lat !== 1) $display("FAIL areset_idle_latency got %0d want 1", lat); else n_pass++;
        n_chk++; if (q1 !== 32'd1) $display("FAIL areset_mem_kept got %h want 1", q1); else n_pass++;
    endtask

    initial begin
        n_chk = 0; n_pass = 0;
        rst_n = 1'b0; use_w0 = 1'b0;
        cyc = 1'b0; stb = 1'b0; wen = 1'b0; sel = 4'h0; wdat = '0; adr = '0; cti = CTI_CLASSIC;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_classic();
        test_byte_lanes();
        test_burst();
        test_pause_abort();
        test_out_of_range();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
